// File: rtl/mor1kx_icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// mor1kx_icache_refill_ctrl
//
// Purpose:
//   Instruction-cache line refill engine. It fetches one cache line from a
//   Wishbone bus in critical-word-first order. Each returned word goes to the
//   cache as a single-cycle write strobe.
//
//   States:
//     IDLE  -> waiting for a refill request.
//     FETCH -> bus cycle active.
//     DONE  -> one cycle; carries the last write strobe.
//
//   A bus error aborts the line. The error is reported as a one-cycle pulse.
//
// Configuration:
//   MOR1KX_ICACHE_REFILL_BURST_EN
//     Defined   -> the line is fetched as a single wrapped burst
//                  (cti 010 ... 111, bte 01 for 4 words / 10 for 8 words).
//     Undefined -> the line is fetched as classic single reads
//                  (cti/bte 0, stb dropped for one cycle after every beat).
//
// Parameters:
//   OPTION_OPERAND_WIDTH      bus address/data width (default 32)
//   OPTION_ICACHE_BLOCK_WIDTH log2 line size in bytes; 4 (4 words) or 5 (8 words)
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//
//   Cache side:
//     refill_req_i  in   line request
//     refill_adr_i  in   miss address
//     wradr_o       out  cache write address
//     wrdat_o       out  cache write data
//     we_o          out  cache write strobe
//     err_o         out  bus error pulse
//     busy_o        out  engine not idle
//
//   Bus side:
//     wbm_adr_o, wbm_cyc_o, wbm_stb_o, wbm_cti_o, wbm_bte_o  out  Wishbone master
//     wbm_dat_i, wbm_ack_i, wbm_err_i                         in   Wishbone master
// -----------------------------------------------------------------------------
module mor1kx_icache_refill_ctrl #(
  parameter int OPTION_OPERAND_WIDTH      = 32,
  parameter int OPTION_ICACHE_BLOCK_WIDTH = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  // cache side
  input  logic                            refill_req_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] refill_adr_i,
  output logic [OPTION_OPERAND_WIDTH-1:0] wradr_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] wrdat_o,
  output logic                            we_o,
  output logic                            err_o,
  output logic                            busy_o,
  // bus side
  output logic [OPTION_OPERAND_WIDTH-1:0] wbm_adr_o,
  output logic                            wbm_cyc_o,
  output logic                            wbm_stb_o,
  output logic [2:0]                      wbm_cti_o,
  output logic [1:0]                      wbm_bte_o,
  input  logic [OPTION_OPERAND_WIDTH-1:0] wbm_dat_i,
  input  logic                            wbm_ack_i,
  input  logic                            wbm_err_i
);

  localparam int AW = OPTION_OPERAND_WIDTH;
  localparam int BW = OPTION_ICACHE_BLOCK_WIDTH;
  // word-index width inside a line; also the beat counter width
  localparam int CW = BW - 2;
  // wrap length code for the burst: 4-beat wrap = 01, 8-beat wrap = 10
  localparam logic [1:0] BTE_WRAP = (CW == 2) ? 2'b01 : 2'b10;

`ifdef MOR1KX_ICACHE_REFILL_BURST_EN
  localparam logic BURST = 1'b1;
`else
  localparam logic BURST = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_adr;
  logic [CW-1:0]   r_cnt;
  logic            r_stb;
  logic            r_we;
  logic            r_err;
  logic [AW-1:0]   r_wradr;
  logic [AW-1:0]   r_wrdat;

  state_t          w_state_next;
  logic [AW-1:0]   w_adr_next;
  logic [CW-1:0]   w_cnt_next;
  logic            w_stb_next;
  logic            w_we_next;
  logic            w_err_next;
  logic [AW-1:0]   w_wradr_next;
  logic [AW-1:0]   w_wrdat_next;

  logic            w_stb;
  logic            w_last;
  logic [CW-1:0]   w_word_inc;
  logic [AW-1:0]   w_adr_inc;

  assign w_stb  = r_stb & (r_state == S_FETCH);
  assign w_last = &r_cnt;

  // Only the word index inside the line advances. Its carry is dropped, so
  // the address wraps within the line and the line bits are never touched.
  assign w_word_inc = r_adr[BW-1:2] + CW'(1);
  assign w_adr_inc  = {r_adr[AW-1:BW], w_word_inc, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_adr   <= '0;
      r_cnt   <= '0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_wradr <= '0;
      r_wrdat <= '0;
    end else begin
      r_state <= w_state_next;
      r_adr   <= w_adr_next;
      r_cnt   <= w_cnt_next;
      r_stb   <= w_stb_next;
      r_we    <= w_we_next;
      r_err   <= w_err_next;
      r_wradr <= w_wradr_next;
      r_wrdat <= w_wrdat_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_adr_next   = r_adr;
    w_cnt_next   = r_cnt;
    w_stb_next   = r_stb;
    w_we_next    = 1'b0;
    w_err_next   = 1'b0;
    w_wradr_next = r_wradr;
    w_wrdat_next = r_wrdat;

    case (r_state)
      S_IDLE: begin
        if (refill_req_i) begin
          w_state_next = S_FETCH;
          w_adr_next   = refill_adr_i & ~AW'(3);
          w_cnt_next   = '0;
          w_stb_next   = 1'b1;
        end
      end

      S_FETCH: begin
        if (!r_stb) begin
          // End of the one-cycle gap between classic single reads.
          w_stb_next = 1'b1;
        end else if (wbm_err_i) begin
          // The error wins over a simultaneous ack. The line is abandoned.
          w_state_next = S_IDLE;
          w_stb_next   = 1'b0;
          w_err_next   = 1'b1;
        end else if (wbm_ack_i) begin
          w_we_next    = 1'b1;
          w_wradr_next = r_adr;
          w_wrdat_next = wbm_dat_i;
          w_adr_next   = w_adr_inc;
          w_cnt_next   = r_cnt + CW'(1);
          if (w_last) begin
            w_state_next = S_DONE;
            w_stb_next   = 1'b0;
          end else begin
            // A burst keeps stb asserted; classic reads insert a gap.
            w_stb_next = BURST;
          end
        end
      end

      // DONE is the cycle of the last write strobe. Requests are ignored here.
      S_DONE:  w_state_next = S_IDLE;

      default: w_state_next = S_IDLE;
    endcase
  end

  assign busy_o    = (r_state != S_IDLE);
  assign we_o      = r_we;
  assign err_o     = r_err;
  assign wradr_o   = r_wradr;
  assign wrdat_o   = r_wrdat;

  assign wbm_adr_o = r_adr;
  assign wbm_cyc_o = (r_state == S_FETCH);
  assign wbm_stb_o = w_stb;
  assign wbm_cti_o = (BURST && w_stb) ? (w_last ? 3'b111 : 3'b010) : 3'b000;
  assign wbm_bte_o = (BURST && w_stb) ? BTE_WRAP : 2'b00;

endmodule

// File: tb/tb_mor1kx_icache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mor1kx_icache_refill_ctrl
//
// Test structure:
//   Two instances of the refill engine share one clock and one reset:
//     index 0 -> 4-word line (block width 4)
//     index 1 -> 8-word line (block width 5)
//   Only the instance under test sees stimulus; the other instance stays idle.
//
// Expected behaviour (reference model):
//   Beat k of a line is fetched from
//     line_base | ((start_offset + 4*k) mod line_bytes).
//   Bus data is random.
//   Each accepted beat must produce exactly one write, one cycle later.
//
// Timing convention:
//   Outputs are sampled on the falling edge.
//   New inputs are driven on the same falling edge, after sampling.
// -----------------------------------------------------------------------------
module tb_mor1kx_icache_refill_ctrl;

`ifdef MOR1KX_ICACHE_REFILL_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        clk;
  logic        rst;

  // inputs driven by the testbench, one entry per instance
  logic        req     [2];
  logic [31:0] radr    [2];
  logic [31:0] dat     [2];
  logic        ack     [2];
  logic        berr    [2];

  // outputs observed from each instance
  logic [31:0] wradr   [2];
  logic [31:0] wrdat   [2];
  logic        we      [2];
  logic        err_o   [2];
  logic        busy    [2];
  logic [31:0] bus_adr [2];
  logic        cyc     [2];
  logic        stb     [2];
  logic [2:0]  cti     [2];
  logic [1:0]  bte     [2];

  int errors;
  int checks;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mor1kx_icache_refill_ctrl #(
      .OPTION_OPERAND_WIDTH      (32),
      .OPTION_ICACHE_BLOCK_WIDTH (4 + gi)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .refill_req_i (req[gi]),
      .refill_adr_i (radr[gi]),
      .wradr_o      (wradr[gi]),
      .wrdat_o      (wrdat[gi]),
      .we_o         (we[gi]),
      .err_o        (err_o[gi]),
      .busy_o       (busy[gi]),
      .wbm_adr_o    (bus_adr[gi]),
      .wbm_cyc_o    (cyc[gi]),
      .wbm_stb_o    (stb[gi]),
      .wbm_cti_o    (cti[gi]),
      .wbm_bte_o    (bte[gi]),
      .wbm_dat_i    (dat[gi]),
      .wbm_ack_i    (ack[gi]),
      .wbm_err_i    (berr[gi])
    );
  end

  // ---------------------------------------------------------------------------
  // do_refill: runs one line refill on instance `sel` and checks it cycle by
  // cycle against the reference model.
  //
  //   err_beat  beat index that gets wbm_err_i (-1 = no error)
  //   err_ack   also raise ack on that beat
  //   max_wait  maximum random wait states before each ack
  //   rst_after beat index after which reset is applied (-1 = no reset)
  //   hold_req  keep refill_req_i high through the whole line
  //   n_we      returns the number of write strobes observed
  // ---------------------------------------------------------------------------
  task automatic do_refill(input int sel, input logic [31:0] adr, input int err_beat,
                           input bit err_ack, input int max_wait, input int rst_after,
                           input bit hold_req, output int n_we);
    int          n;
    int          waits;
    logic [31:0] line, base, off, a, a0, d;
    logic [2:0]  ecti;
    logic [1:0]  ebte;
    bit          exp_we;
    logic [31:0] exp_wa, exp_wd;

    n      = (sel == 1) ? 8 : 4;
    line   = 32'(n * 4);
    base   = adr & ~(line - 32'd1);
    off    = adr & (line - 32'd1) & ~32'd3;
    a0     = base | off;
    n_we   = 0;
    exp_we = 1'b0;
    exp_wa = '0;
    exp_wd = '0;
    $display("refill inst=%0d adr=%h err_beat=%0d err_ack=%0d max_wait=%0d rst_after=%0d hold=%0d",
             sel, adr, err_beat, err_ack, max_wait, rst_after, hold_req);

    @(negedge clk);
    checks++;
    if (busy[sel] !== 1'b0 || cyc[sel] !== 1'b0)
      begin errors++; $display("FAIL idle_before: busy=%b cyc=%b want 0 0", busy[sel], cyc[sel]); end
    req[sel]  = 1'b1;
    radr[sel] = adr;

    @(negedge clk);
    // Scramble the address input after the request, so the latch is actually tested.
    if (!hold_req) begin
      req[sel]  = 1'b0;
      radr[sel] = $urandom;
    end

    for (int k = 0; k < n; k++) begin
      a     = base | ((off + 32'(4 * k)) % line);
      ecti  = BURST ? ((k == n - 1) ? 3'b111 : 3'b010) : 3'b000;
      ebte  = BURST ? ((n == 4) ? 2'b01 : 2'b10) : 2'b00;
      waits = int'($urandom_range(max_wait, 0));
      d     = '0;

      for (int w = 0; w <= waits; w++) begin
        checks++;
        if (cyc[sel] !== 1'b1 || stb[sel] !== 1'b1)
          begin errors++; $display("FAIL request k=%0d: cyc=%b stb=%b want 1 1", k, cyc[sel], stb[sel]); end
        checks++;
        if (bus_adr[sel] !== a)
          begin errors++; $display("FAIL bus_adr k=%0d: got %h want %h", k, bus_adr[sel], a); end
        checks++;
        if (cti[sel] !== ecti || bte[sel] !== ebte)
          begin errors++; $display("FAIL cti_bte k=%0d: got %b/%b want %b/%b", k, cti[sel], bte[sel], ecti, ebte); end
        checks++;
        if (we[sel] !== exp_we || (exp_we && (wradr[sel] !== exp_wa || wrdat[sel] !== exp_wd)))
          begin errors++; $display("FAIL write k=%0d: we=%b adr=%h dat=%h want we=%b adr=%h dat=%h",
                                   k, we[sel], wradr[sel], wrdat[sel], exp_we, exp_wa, exp_wd); end
        if (we[sel] === 1'b1) n_we++;
        exp_we = 1'b0;

        d        = $urandom;
        dat[sel] = d;
        if (w == waits) begin
          ack[sel]  = (k == err_beat) ? err_ack : 1'b1;
          berr[sel] = (k == err_beat);
        end

        @(negedge clk);
        ack[sel]  = 1'b0;
        berr[sel] = 1'b0;
        dat[sel]  = $urandom;
      end

      if (k == err_beat) begin
        // T+1: bus released, error pulse, no write for this beat
        checks++;
        if (cyc[sel] !== 1'b0 || stb[sel] !== 1'b0)
          begin errors++; $display("FAIL err_drop: cyc=%b stb=%b want 0 0", cyc[sel], stb[sel]); end
        checks++;
        if (err_o[sel] !== 1'b1)
          begin errors++; $display("FAIL err_pulse: got %b want 1", err_o[sel]); end
        checks++;
        if (we[sel] !== 1'b0)
          begin errors++; $display("FAIL err_we: got %b want 0", we[sel]); end
        if (we[sel] === 1'b1) n_we++;

        @(negedge clk);
        // T+2: idle, pulse over
        checks++;
        if (err_o[sel] !== 1'b0 || busy[sel] !== 1'b0 || cyc[sel] !== 1'b0 || we[sel] !== 1'b0)
          begin errors++; $display("FAIL err_after: err=%b busy=%b cyc=%b we=%b want 0 0 0 0",
                                   err_o[sel], busy[sel], cyc[sel], we[sel]); end
        if (we[sel] === 1'b1) n_we++;
        return;
      end

      exp_we = 1'b1;
      exp_wa = a;
      exp_wd = d;

      if (k == rst_after) begin
        checks++;
        if (we[sel] !== 1'b1 || wradr[sel] !== a || wrdat[sel] !== d)
          begin errors++; $display("FAIL rst_we: we=%b adr=%h dat=%h want 1 %h %h", we[sel], wradr[sel], wrdat[sel], a, d); end
        if (we[sel] === 1'b1) n_we++;

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (cyc[sel] !== 1'b0 || stb[sel] !== 1'b0 || we[sel] !== 1'b0 || busy[sel] !== 1'b0 || err_o[sel] !== 1'b0)
          begin errors++; $display("FAIL rst_mid_ctl: cyc=%b stb=%b we=%b busy=%b err=%b want 0",
                                   cyc[sel], stb[sel], we[sel], busy[sel], err_o[sel]); end
        checks++;
        if (bus_adr[sel] !== 32'd0 || wradr[sel] !== 32'd0 || wrdat[sel] !== 32'd0 || cti[sel] !== 3'd0 || bte[sel] !== 2'd0)
          begin errors++; $display("FAIL rst_mid_bus: adr=%h wradr=%h wrdat=%h cti=%b bte=%b want 0",
                                   bus_adr[sel], wradr[sel], wrdat[sel], cti[sel], bte[sel]); end
        return;
      end

      if (!BURST && k != n - 1) begin
        // Classic mode: one-cycle strobe gap after every beat but the last.
        checks++;
        if (stb[sel] !== 1'b0)
          begin errors++; $display("FAIL stb_gap k=%0d: got %b want 0", k, stb[sel]); end
        checks++;
        if (we[sel] !== 1'b1 || wradr[sel] !== a || wrdat[sel] !== d)
          begin errors++; $display("FAIL gap_we k=%0d: we=%b adr=%h dat=%h want 1 %h %h", k, we[sel], wradr[sel], wrdat[sel], a, d); end
        if (we[sel] === 1'b1) n_we++;
        exp_we = 1'b0;
        @(negedge clk);
      end
    end

    // DONE cycle: bus released, last write
    checks++;
    if (busy[sel] !== 1'b1 || cyc[sel] !== 1'b0 || stb[sel] !== 1'b0)
      begin errors++; $display("FAIL done: busy=%b cyc=%b stb=%b want 1 0 0", busy[sel], cyc[sel], stb[sel]); end
    checks++;
    if (we[sel] !== 1'b1 || wradr[sel] !== exp_wa || wrdat[sel] !== exp_wd)
      begin errors++; $display("FAIL done_we: we=%b adr=%h dat=%h want 1 %h %h", we[sel], wradr[sel], wrdat[sel], exp_wa, exp_wd); end
    if (we[sel] === 1'b1) n_we++;

    @(negedge clk);
    // IDLE cycle: no restart from DONE; write port holds its last values
    checks++;
    if (busy[sel] !== 1'b0 || cyc[sel] !== 1'b0 || we[sel] !== 1'b0)
      begin errors++; $display("FAIL idle_after: busy=%b cyc=%b we=%b want 0 0 0", busy[sel], cyc[sel], we[sel]); end
    checks++;
    if (wradr[sel] !== exp_wa || wrdat[sel] !== exp_wd)
      begin errors++; $display("FAIL hold: adr=%h dat=%h want %h %h", wradr[sel], wrdat[sel], exp_wa, exp_wd); end
    if (we[sel] === 1'b1) n_we++;

    if (hold_req) begin
      @(negedge clk);
      req[sel] = 1'b0;
      checks++;
      if (cyc[sel] !== 1'b1 || bus_adr[sel] !== a0)
        begin errors++; $display("FAIL restart: cyc=%b adr=%h want 1 %h", cyc[sel], bus_adr[sel], a0); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req[s]  = 1'b1;
      radr[s] = $urandom;
    end
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (busy[s] !== 1'b0 || cyc[s] !== 1'b0 || stb[s] !== 1'b0 || we[s] !== 1'b0 || err_o[s] !== 1'b0)
        begin errors++; $display("FAIL reset_ctl inst=%0d: busy=%b cyc=%b stb=%b we=%b err=%b want 0",
                                 s, busy[s], cyc[s], stb[s], we[s], err_o[s]); end
      checks++;
      if (bus_adr[s] !== 32'd0 || wradr[s] !== 32'd0 || wrdat[s] !== 32'd0 || cti[s] !== 3'd0 || bte[s] !== 2'd0)
        begin errors++; $display("FAIL reset_bus inst=%0d: adr=%h wradr=%h wrdat=%h cti=%b bte=%b want 0",
                                 s, bus_adr[s], wradr[s], wrdat[s], cti[s], bte[s]); end
      req[s] = 1'b0;
    end
    rst = 1'b0;
  endtask

  task automatic test_wrap_line();
    int n_we;
    do_refill(1, 32'h0000_1014, -1, 1'b0, 0, -1, 1'b0, n_we);
    checks++;
    if (n_we !== 8) begin errors++; $display("FAIL wrap_count: got %0d want 8", n_we); end
  endtask

  task automatic test_bus_error();
    int n_we;
    do_refill(1, $urandom, 2, 1'b0, 1, -1, 1'b0, n_we);
    checks++;
    if (n_we !== 2) begin errors++; $display("FAIL err_count: got %0d want 2", n_we); end
  endtask

  task automatic test_ack_err_together();
    int n_we;
    do_refill(0, $urandom, 0, 1'b1, 0, -1, 1'b0, n_we);
    checks++;
    if (n_we !== 0) begin errors++; $display("FAIL ackerr_count: got %0d want 0", n_we); end
  endtask

  task automatic test_reset_mid_burst();
    int n_we;
    do_refill(1, $urandom, -1, 1'b0, 0, 3, 1'b0, n_we);
    checks++;
    if (n_we !== 4) begin errors++; $display("FAIL rstmid_count: got %0d want 4", n_we); end
    do_refill(1, $urandom, -1, 1'b0, 0, -1, 1'b0, n_we);
    checks++;
    if (n_we !== 8) begin errors++; $display("FAIL fresh_count: got %0d want 8", n_we); end
  endtask

  task automatic test_hold_req();
    int n_we;
    do_refill(0, $urandom, -1, 1'b0, 0, -1, 1'b1, n_we);
    checks++;
    if (n_we !== 4) begin errors++; $display("FAIL hold_count: got %0d want 4", n_we); end
  endtask

  task automatic test_wait_states();
    int n_we;
    do_refill(0, $urandom, -1, 1'b0, 3, -1, 1'b0, n_we);
    checks++;
    if (n_we !== 4) begin errors++; $display("FAIL wait_count: got %0d want 4", n_we); end
  endtask

  task automatic test_random();
    int n_we, sel, eb, exp_n;
    for (int i = 0; i < 20; i++) begin
      sel   = int'($urandom_range(1, 0));
      eb    = ($urandom_range(3, 0) == 0) ? int'($urandom_range((sel == 1) ? 7 : 3, 0)) : -1;
      exp_n = (eb >= 0) ? eb : ((sel == 1) ? 8 : 4);
      do_refill(sel, $urandom, eb, 1'($urandom_range(1, 0)), 3, -1, 1'b0, n_we);
      checks++;
      if (n_we !== exp_n) begin errors++; $display("FAIL rand_count i=%0d: got %0d want %0d", i, n_we, exp_n); end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    for (int s = 0; s < 2; s++) begin
      req[s]  = 1'b0;
      radr[s] = '0;
      dat[s]  = '0;
      ack[s]  = 1'b0;
      berr[s] = 1'b0;
    end

    test_reset();
    test_wrap_line();
    test_bus_error();
    test_ack_err_together();
    test_reset_mid_burst();
    test_hold_req();
    test_wait_states();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
